// File: rtl/z80_bus_master.sv
// Z80 bus master: runs one opcode-fetch, memory or IO bus cycle per command,
// one T-state per clock, and returns a single-clock completion response.
// Optional macro Z80_REFRESH_EN adds the refresh phase (R counter, nRFSH) to fetches.
module z80_bus_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_type,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        n_mreq,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_m1,
  output logic        n_rfsh,
  input  logic        n_wait
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 7;

  localparam logic [2:0] CT_FETCH = 3'd0;
  localparam logic [2:0] CT_MRD   = 3'd1;
  localparam logic [2:0] CT_MWR   = 3'd2;
  localparam logic [2:0] CT_IORD  = 3'd3;
  localparam logic [2:0] CT_IOWR  = 3'd4;

  // Asserted-strobe bit masks: {mreq, iorq, rd, wr, m1, rfsh, oe}
  localparam logic [6:0] B_MREQ = 7'b1000000;
  localparam logic [6:0] B_IORQ = 7'b0100000;
  localparam logic [6:0] B_RD   = 7'b0010000;
  localparam logic [6:0] B_WR   = 7'b0001000;
  localparam logic [6:0] B_M1   = 7'b0000100;
  localparam logic [6:0] B_RFSH = 7'b0000010;
  localparam logic [6:0] B_OE   = 7'b0000001;

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

  state_t          state, state_n;
  logic [2:0]      cyc_type, type_n;
  logic [AW-1:0]   cyc_addr, addr_n;
  logic [DW-1:0]   cyc_wdata, wdata_n, fetch_data;
  logic            accept, is_io, legal_n;
  logic            early, active, mid;
  logic [6:0]      strb_n;
`ifdef Z80_REFRESH_EN
  logic [RW-1:0]   r_cnt;
`endif

  // Next T-state; the auto wait of IO cycles and nWAIT-driven waits share TW
  always_comb begin
    accept  = (state == IDLE) && cmd_valid && cmd_ready;
    type_n  = accept ? cmd_type  : cyc_type;
    addr_n  = accept ? cmd_addr  : cyc_addr;
    wdata_n = accept ? cmd_wdata : cyc_wdata;
    legal_n = (type_n <= CT_IOWR);
    is_io   = (cyc_type == CT_IORD) || (cyc_type == CT_IOWR);
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = T1;
      T1:      state_n = (cyc_type > CT_IOWR) ? IDLE : T2;
      T2:      state_n = (is_io || !n_wait) ? TW : T3;
      TW:      state_n = n_wait ? T3 : TW;
      T3:      state_n = (cyc_type == CT_FETCH) ? T4 : IDLE;
      T4:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes to present during the upcoming T-state
  always_comb begin
    strb_n = '0;
    early  = (state_n == T1) || (state_n == T2) || (state_n == TW);
    mid    = (state_n == T2) || (state_n == TW) || (state_n == T3);
    active = early || (state_n == T3);
    case (type_n)
      CT_FETCH: begin
        if (early) strb_n = B_MREQ | B_RD | B_M1;
`ifdef Z80_REFRESH_EN
        else if (state_n == T3) strb_n = B_MREQ | B_RFSH;
        else if (state_n == T4) strb_n = B_RFSH;
`endif
      end
      CT_MRD:  if (active) strb_n = B_MREQ | B_RD;
      CT_MWR:  if (active) strb_n = B_MREQ | B_OE | (mid ? B_WR : 7'b0);
      CT_IORD: if (mid) strb_n = B_IORQ | B_RD;
      CT_IOWR: if (active) strb_n = B_OE | (mid ? (B_IORQ | B_WR) : 7'b0);
      default: strb_n = '0;
    endcase
  end

  // State, command latch, registered bus outputs and response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cyc_type   <= '0;
      cyc_addr   <= '0;
      cyc_wdata  <= '0;
      fetch_data <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      a          <= '0;
      d_out      <= '0;
      d_oe       <= 1'b0;
      n_mreq     <= 1'b1;
      n_iorq     <= 1'b1;
      n_rd       <= 1'b1;
      n_wr       <= 1'b1;
      n_m1       <= 1'b1;
      n_rfsh     <= 1'b1;
`ifdef Z80_REFRESH_EN
      r_cnt      <= '0;
`endif
    end else begin
      state     <= state_n;
      cmd_ready <= (state_n == IDLE);
      rsp_valid <= (state != IDLE) && (state_n == IDLE);
      if (accept) begin
        cyc_type  <= cmd_type;
        cyc_addr  <= cmd_addr;
        cyc_wdata <= cmd_wdata;
      end
      if ((state == T2 || state == TW) && state_n == T3 && cyc_type == CT_FETCH)
        fetch_data <= d_in;
      if (state != IDLE && state_n == IDLE) begin
        case (cyc_type)
          CT_FETCH:         rsp_data <= fetch_data;
          CT_MRD, CT_IORD:  rsp_data <= d_in;
          CT_MWR, CT_IOWR:  rsp_data <= 8'h00;
          default:          rsp_data <= 8'hFF;
        endcase
      end
      {n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh} <= ~strb_n[6:1];
      d_oe <= strb_n[0];
      if (strb_n[0]) d_out <= wdata_n;
`ifdef Z80_REFRESH_EN
      if (type_n == CT_FETCH && (state_n == T3 || state_n == T4))
        a <= {8'h00, 1'b0, r_cnt};
      else
`endif
      if (state_n != IDLE && legal_n) a <= addr_n;
`ifdef Z80_REFRESH_EN
      if (state == T4 && state_n == IDLE) r_cnt <= r_cnt + RW'(1);
`endif
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: random command stream against a cycle-indexed
// behavioural model, plus pinned literal expectations for directed cycles.
module tb_z80_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_type;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [15:0] a;
  logic [7:0]  d_out, d_in;
  logic        d_oe;
  logic        n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh, n_wait;

  always #5 clk = ~clk;

  z80_bus_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .a(a), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
    .n_mreq(n_mreq), .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr),
    .n_m1(n_m1), .n_rfsh(n_rfsh), .n_wait(n_wait)
  );

  typedef struct {
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        cmd_ready;
    logic        chk_a;
    logic [15:0] a;
    logic        d_oe;
    logic [7:0]  d_out;
    logic        n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh;
  } exp_t;

  exp_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int model_r = 0;
  int cnt_mreq, cnt_iorq, cnt_rd, cnt_wr, cnt_m1, cnt_oe;
  logic [15:0] refresh_a;
  logic [7:0]  last_rsp;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t idle_exp(logic ready, logic rv, logic [7:0] rd);
    exp_t e;
    e.rsp_valid = rv;  e.rsp_data = rd;  e.cmd_ready = ready;
    e.chk_a = 1'b0;    e.a = 16'h0;      e.d_oe = 1'b0;  e.d_out = 8'h00;
    e.n_mreq = 1'b1; e.n_iorq = 1'b1; e.n_rd = 1'b1; e.n_wr = 1'b1;
    e.n_m1 = 1'b1;   e.n_rfsh = 1'b1;
    return e;
  endfunction

  // Compare DUT against the model's expectation for this clock
  always @(negedge clk) begin : compare
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("cmd_ready", 32'(cmd_ready), 32'(e.cmd_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e.rsp_valid));
      if (e.rsp_valid) chk("rsp_data", 32'(rsp_data), 32'(e.rsp_data));
      chk("n_mreq", 32'(n_mreq), 32'(e.n_mreq));
      chk("n_iorq", 32'(n_iorq), 32'(e.n_iorq));
      chk("n_rd", 32'(n_rd), 32'(e.n_rd));
      chk("n_wr", 32'(n_wr), 32'(e.n_wr));
      chk("n_m1", 32'(n_m1), 32'(e.n_m1));
      chk("n_rfsh", 32'(n_rfsh), 32'(e.n_rfsh));
      chk("d_oe", 32'(d_oe), 32'(e.d_oe));
      if (e.d_oe) chk("d_out", 32'(d_out), 32'(e.d_out));
      if (e.chk_a) chk("addr", 32'(a), 32'(e.a));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    d_in = 8'($urandom);
    n_wait = 1'($urandom_range(0, 1));
    expq.push_back(idle_exp(1'b1, 1'b0, 8'h00));
  endtask

  // Issue one command from an IDLE/ready cycle and model it cycle by cycle
  task automatic run_cmd(input int typ, input logic [15:0] addr, input logic [7:0] wdata,
                         input int w, input int din_fix, input int abort_at);
    bit fetch, mrd, mwr, iord, iowr, legal;
    int n, first;
    logic [7:0] exp_rsp;
    exp_t e;
    fetch = (typ == 0); mrd = (typ == 1); mwr = (typ == 2);
    iord = (typ == 3);  iowr = (typ == 4); legal = (typ <= 4);
    if (fetch) n = 4 + w;
    else if (mrd || mwr) n = 3 + w;
    else if (iord || iowr) n = 4 + w;
    else n = 1;
    first = (iord || iowr) ? 2 : 1;
    exp_rsp = mwr || iowr ? 8'h00 : 8'hFF;
    cnt_mreq = 0; cnt_iorq = 0; cnt_rd = 0; cnt_wr = 0; cnt_m1 = 0; cnt_oe = 0;
    refresh_a = 16'hFFFF;
    cmd_valid = 1'b1; cmd_type = 3'(typ); cmd_addr = addr; cmd_wdata = wdata;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_type = 3'($urandom); cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom);
      d_in = (din_fix >= 0) ? 8'(din_fix) : 8'($urandom);
      if (legal && k >= first && k <= first + w) n_wait = (k < first + w) ? 1'b0 : 1'b1;
      else n_wait = 1'($urandom_range(0, 1));
      if (fetch && k == 1 + w) exp_rsp = d_in;
      if ((mrd || iord) && k == n - 1) exp_rsp = d_in;
      if (k == abort_at) begin
        #1 reset = 1'b1;
        #1;
        chk("abort_n_iorq", 32'(n_iorq), 32'd1);
        chk("abort_n_rd", 32'(n_rd), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        model_r = 0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        expq.push_back(idle_exp(1'b0, 1'b0, 8'h00));
        @(posedge clk); #1;
        expq.push_back(idle_exp(1'b1, 1'b0, 8'h00));
        return;
      end
      e = idle_exp(1'b0, 1'b0, 8'h00);
      e.chk_a = legal; e.a = addr;
      if (fetch) begin
        if (k < 2 + w) begin e.n_mreq = 1'b0; e.n_rd = 1'b0; e.n_m1 = 1'b0; end
`ifdef Z80_REFRESH_EN
        else begin
          if (k == 2 + w) e.n_mreq = 1'b0;
          e.n_rfsh = 1'b0;
          e.a = 16'(model_r);
        end
`endif
      end
      if (mrd) begin e.n_mreq = 1'b0; e.n_rd = 1'b0; end
      if (mwr) begin
        e.n_mreq = 1'b0; e.d_oe = 1'b1; e.d_out = wdata;
        if (k >= 1) e.n_wr = 1'b0;
      end
      if (iord && k >= 1) begin e.n_iorq = 1'b0; e.n_rd = 1'b0; end
      if (iowr) begin
        e.d_oe = 1'b1; e.d_out = wdata;
        if (k >= 1) begin e.n_iorq = 1'b0; e.n_wr = 1'b0; end
      end
      expq.push_back(e);
      if (!n_mreq) cnt_mreq++;
      if (!n_iorq) cnt_iorq++;
      if (!n_rd) cnt_rd++;
      if (!n_wr) cnt_wr++;
      if (!n_m1) cnt_m1++;
      if (d_oe) cnt_oe++;
      if (fetch && k == 2 + w) refresh_a = a;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    d_in = 8'($urandom);
    n_wait = 1'($urandom_range(0, 1));
    expq.push_back(idle_exp(1'b1, 1'b1, exp_rsp));
    last_rsp = rsp_data;
    if (fetch) model_r = (model_r + 1) % 128;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_type = 3'd0; cmd_addr = 16'h0;
    cmd_wdata = 8'h0; d_in = 8'h0; n_wait = 1'b1;
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_addr", 32'(a), 32'd0);
    chk("reset_d_out", 32'(d_out), 32'd0);
    chk("reset_d_oe", 32'(d_oe), 32'd0);
    chk("reset_strobes", 32'({n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh}), 32'h3F);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    expq.push_back(idle_exp(1'b0, 1'b0, 8'h00));
    @(posedge clk); #1;
    expq.push_back(idle_exp(1'b1, 1'b0, 8'h00));

    // Opcode fetch at 0x0000 returning 0xF3
    run_cmd(0, 16'h0000, 8'h00, 0, 8'hF3, -1);
    chk("fetch_rsp", 32'(last_rsp), 32'hF3);
    chk("fetch_m1_clocks", 32'(cnt_m1), 32'd2);
    chk("fetch_rd_clocks", 32'(cnt_rd), 32'd2);
`ifdef Z80_REFRESH_EN
    chk("fetch_refresh_a0", 32'(refresh_a), 32'h0000);
    chk("fetch_mreq_clocks", 32'(cnt_mreq), 32'd3);
    run_cmd(0, 16'h1234, 8'h00, 0, -1, -1);
    chk("fetch_refresh_a1", 32'(refresh_a), 32'h0001);
`else
    chk("fetch_mreq_clocks", 32'(cnt_mreq), 32'd2);
`endif
    idle_cycle();

    // Memory write 0x2000 = 0x5A
    run_cmd(2, 16'h2000, 8'h5A, 0, -1, -1);
    chk("mwr_wr_clocks", 32'(cnt_wr), 32'd2);
    chk("mwr_oe_clocks", 32'(cnt_oe), 32'd3);
    chk("mwr_rsp", 32'(last_rsp), 32'h00);

    // IO write 0x003F = 0xA5
    run_cmd(4, 16'h003F, 8'hA5, 0, -1, -1);
    chk("iowr_iorq_clocks", 32'(cnt_iorq), 32'd3);
    chk("iowr_wr_clocks", 32'(cnt_wr), 32'd3);
    chk("iowr_mreq_clocks", 32'(cnt_mreq), 32'd0);

    // Memory read 0x0604 with three wait states
    run_cmd(1, 16'h0604, 8'h00, 3, 8'h3C, -1);
    chk("mrd_rd_clocks", 32'(cnt_rd), 32'd6);
    chk("mrd_rsp", 32'(last_rsp), 32'h3C);

    // IO read aborted by reset in its automatic wait state
    run_cmd(3, 16'h0042, 8'h00, 2, -1, 2);
`ifdef Z80_REFRESH_EN
    run_cmd(0, 16'h4444, 8'h00, 0, -1, -1);
    chk("refresh_after_reset", 32'(refresh_a), 32'h0000);
`endif

    // Illegal command then back-to-back memory reads
    run_cmd(6, 16'hBEEF, 8'h11, 0, -1, -1);
    chk("illegal_rsp", 32'(last_rsp), 32'hFF);
    chk("illegal_strobes", 32'(cnt_mreq + cnt_iorq + cnt_rd + cnt_wr), 32'd0);
    run_cmd(1, 16'h0100, 8'h00, 0, -1, -1);
    run_cmd(1, 16'h0101, 8'h00, 1, -1, -1);

    // Random command stream
    for (int i = 0; i < 200; i++) begin
      int typ, gap;
      typ = $urandom_range(0, 5);
      if (typ == 5) typ = $urandom_range(5, 7);
      run_cmd(typ, 16'($urandom), 8'($urandom), $urandom_range(0, 3), -1, -1);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
    end

    @(posedge clk); @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
